paddle_control: RTL and testbench
=================================

# paddle_control

Upstream stage of the ball logic: converts the four raw player push-buttons into the two paddle positions `player_1_x` / `player_2_x` that the ball module compares against. Each button is synchronised and debounced. Paddles move at a fixed prescaled rate and saturate at the playfield edges. All outputs are registered.

## Interface
Parameters:
- `PADDLE_LEN`, 32: paddle length in pixels.
- `MIN_POS`, 0: lowest legal paddle position (top edge of paddle).
- `MAX_POS`, 240: playfield extent. Highest legal position is `MAX_POS-PADDLE_LEN`.
- `START_POS`, `(MAX_POS-MIN_POS-PADDLE_LEN)/2` = 104: reset position of both paddles.
- `DEBOUNCE_CYCLES`, 16: cycles a synchronised input must disagree with its debounced state before that state flips. Must be ≥2.
- `STEP_DIV`, 4: clock cycles per move tick. Must be ≥1.
- `STEP`, 2: pixels moved per tick.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `enable`, in, 1: game running. When low, paddles hold position.
- `p1_up`, `p1_down`, in, 1 each: raw asynchronous buttons for player 1, active-high.
- `p2_up`, `p2_down`, in, 1 each: raw asynchronous buttons for player 2, active-high.
- `player_1_x`, out, 9: player 1 paddle position.
- `player_2_x`, out, 9: player 2 paddle position.

## Operation
- **Reset values:** `player_1_x` = `player_2_x` = `START_POS`. All synchroniser flops = 0. Debounced states = 0. Debounce counters = 0. Prescaler = 0.
- **Synchroniser:** each raw button passes through a 2-flop synchroniser (`s1`, `s2`).
- **Debouncer:** one per button; each holds a debounced state `db` and a counter `cnt`.
  - If `s2 == db`: `cnt` ← 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db` ← `s2`, `cnt` ← 0.
  - Else: `cnt` ← `cnt+1`.
  - Any agreeing cycle restarts the count. Glitches shorter than `DEBOUNCE_CYCLES` are rejected.
- **Prescaler:** free-running from 0 to `STEP_DIV-1`, then wraps. `tick` is asserted while it equals `STEP_DIV-1`. It runs regardless of `enable`.
- **Move rule** (per paddle, on a clock edge with `tick & enable`):
  - Only `up_db` set: pos ← max(pos-STEP, MIN_POS).
  - Only `down_db` set: pos ← min(pos+STEP, MAX_POS-PADDLE_LEN).
  - Both set, or neither set: hold.
- **Arithmetic:** computed at 10 bits, so subtraction below 0 cannot wrap. Saturation is exact: a paddle lands on the limit even when the distance to it is not a multiple of `STEP`.
- **Independence:** the two paddles are fully independent. Simultaneous presses by both players both take effect on the same tick.
- **`enable` low:** positions hold, but debouncers and prescaler keep running. Positions are not recentred when `enable` is deasserted.
- **Reset mid-operation:** on the next edge all state takes its reset value, regardless of held buttons or the current prescaler phase.

## Timing
- **Debounce latency:** raw input sampled high at edge 1 gives `s2` high at edge 2. `db` flips at edge `DEBOUNCE_CYCLES+2` (edge 18 with defaults). Release follows the same timing.
- **Move latency:** a position changes on the first `tick` edge at or after the cycle in which `db` is visible. The change is registered, so there is no combinational path from buttons to outputs.
- **Move rate:** `STEP` pixels every `STEP_DIV` cycles, i.e. 0.5 px/cycle with defaults.

## Structure
- **Shared package `pong_pkg`:** `POS_W` = 9, screen extents (240/320), `PADDLE_LEN`, and the typedef `pos_t` = logic [POS_W-1:0]. The ball stage shares these.
- **Sub-module `button_debounce`:** synchroniser plus counter, parameter `DEBOUNCE_CYCLES`, ports `clock`, `reset`, `raw`, `db`. Instantiated four times.
- **Top level:** prescaler and two position registers with saturating update logic.

## Test plan
- **Reset:** assert `reset` 2 cycles with buttons idle. Required: both outputs = 104, and they stay 104 for 100 cycles.
- **Up to top limit:** hold `p1_up`, `enable`=1. Required:
  - First move no earlier than edge 18.
  - `player_1_x` then decreases by 2 every 4 cycles: 104, 102, …, 0.
  - It then holds at 0 while the button stays held.
  - `player_2_x` stays 104 throughout.
- **Down to bottom limit with odd step:** set `STEP`=3 and hold `p2_down`. Required: `player_2_x` steps 104, 107, …, 206, then saturates at exactly 208 and holds.
- **Glitch rejection:** pulse `p1_down` high for 10 cycles, then low. Required: `player_1_x` never changes. Also check a 17-cycle pulse, which must produce movement.
- **Conflicting inputs and enable:** hold `p1_up` and `p1_down` together. Required: no movement. Then hold `p1_up` with `enable`=0. Required: no movement. Raise `enable`. Required: movement on the next tick.
- **Reset mid-motion:** hold `p2_up` until `player_2_x` = 60, then pulse `reset` for 1 cycle with the button still held. Required:
  - `player_2_x` = 104 on the following edge.
  - Movement resumes only after a fresh 18-edge debounce.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared pong geometry (POS_W, screen extents, PADDLE_LEN), pos_t and the saturating paddle step
package pong_pkg;
  localparam int POS_W = 9;
  localparam int SCREEN_H = 240;
  localparam int SCREEN_W = 320;
  localparam int PADDLE_LEN = 32;
  typedef logic [POS_W-1:0] pos_t;
  typedef logic [9:0] wide_t;
  function automatic pos_t step_pos(pos_t pos, logic up, logic dn, wide_t step, wide_t lo, wide_t hi);
    wide_t p;
    p = wide_t'(pos);
    if (up && !dn) p = (p < lo + step) ? lo : p - step;
    else if (dn && !up) p = (p + step > hi) ? hi : p + step;
    return pos_t'(p);
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser plus counter debouncer; ports clock, reset, raw (async button) -> db (debounced level)
module button_debounce
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clock)
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/paddle_control.sv
// paddle_control: buttons p1/p2 up/down -> debounced, prescaled, saturating registered paddle positions player_1_x/player_2_x (clock, reset, enable)
module paddle_control
  import pong_pkg::*;
#(
  parameter int PADDLE_LEN = pong_pkg::PADDLE_LEN,
  parameter int MIN_POS = 0,
  parameter int MAX_POS = 240,
  parameter int START_POS = (MAX_POS - MIN_POS - PADDLE_LEN) / 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_DIV = 4,
  parameter int STEP = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             p1_up,
  input  logic             p1_down,
  input  logic             p2_up,
  input  logic             p2_down,
  output logic [POS_W-1:0] player_1_x,
  output logic [POS_W-1:0] player_2_x
);
  localparam int PW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  logic [3:0] btn, db;
  logic [PW-1:0] pre;
  logic tick;
  pos_t p1_next, p2_next;
  assign btn = {p2_down, p2_up, p1_down, p1_up};
  for (genvar g = 0; g < 4; g++) begin : g_db
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock(clock),
      .reset(reset),
      .raw(btn[g]),
      .db(db[g])
    );
  end
  always_comb begin
    tick = pre == PW'(STEP_DIV - 1);
    p1_next = step_pos(player_1_x, db[0], db[1], 10'(STEP), 10'(MIN_POS), 10'(MAX_POS - PADDLE_LEN));
    p2_next = step_pos(player_2_x, db[2], db[3], 10'(STEP), 10'(MIN_POS), 10'(MAX_POS - PADDLE_LEN));
  end
  always_ff @(posedge clock)
    if (reset) begin
      pre <= '0;
      player_1_x <= POS_W'(START_POS);
      player_2_x <= POS_W'(START_POS);
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick && enable) begin
        player_1_x <= p1_next;
        player_2_x <= p2_next;
      end
    end
endmodule

// File: tb/tb_paddle_control.sv
// tb_paddle_control: table-driven plus directed-sequence self-checking bench for paddle_control
module tb_paddle_control;
  logic clock, reset, enable, p1_up, p1_down, p2_up, p2_down;
  logic [8:0] p1_x, p2_x, p1_x3, p2_x3;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic rst, en, p1u, p1d, p2u, p2d;
    int n, e1, e2;
  } vec_t;
  vec_t tbl[9];
  paddle_control dut (
    .clock(clock), .reset(reset), .enable(enable),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .player_1_x(p1_x), .player_2_x(p2_x)
  );
  paddle_control #(.STEP(3)) dut3 (
    .clock(clock), .reset(reset), .enable(enable),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .player_1_x(p1_x3), .player_2_x(p2_x3)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic chk(input string name, input logic [8:0] act, input int exp);
    tests++;
    if (act !== 9'(exp)) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic idle();
    {p1_up, p1_down, p2_up, p2_down} = 4'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    enable = 1'b1;
    idle();
    // Rows run back to back; edge counts are from reset release, ticks fall on every 4th edge.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 104, 104};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 100, 104, 104};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19, 104, 104};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 102, 104};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 100, 104};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 200, 0, 104};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 40, 0, 104};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20, 2, 104};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 500, 208, 104};
    @(negedge clock);
    for (int i = 0; i < 9; i++) begin
      {reset, enable, p1_up, p1_down, p2_up, p2_down} =
        {tbl[i].rst, tbl[i].en, tbl[i].p1u, tbl[i].p1d, tbl[i].p2u, tbl[i].p2d};
      cyc(tbl[i].n);
      chk($sformatf("tbl%0d_p1", i), p1_x, tbl[i].e1);
      chk($sformatf("tbl%0d_p2", i), p2_x, tbl[i].e2);
    end
    idle();
    do_reset();
    p2_down = 1'b1;
    cyc(19);
    chk("step3_pre", p2_x3, 104);
    cyc(1);
    chk("step3_first", p2_x3, 107);
    for (int k = 2; k <= 34; k++) begin
      cyc(4);
      chk($sformatf("step3_k%0d", k), p2_x3, 104 + 3 * k);
    end
    cyc(4);
    chk("step3_sat", p2_x3, 208);
    cyc(40);
    chk("step3_hold", p2_x3, 208);
    idle();
    do_reset();
    p1_down = 1'b1;
    cyc(10);
    p1_down = 1'b0;
    for (int c = 0; c < 50; c++) begin
      cyc(1);
      chk("glitch10", p1_x, 104);
    end
    do_reset();
    p1_down = 1'b1;
    cyc(17);
    p1_down = 1'b0;
    cyc(43);
    chk("pulse17", p1_x, 112);
    do_reset();
    p1_up = 1'b1;
    p1_down = 1'b1;
    cyc(60);
    chk("conflict", p1_x, 104);
    idle();
    enable = 1'b0;
    do_reset();
    p1_up = 1'b1;
    cyc(30);
    chk("disabled", p1_x, 104);
    enable = 1'b1;
    cyc(1);
    chk("enable_pretick", p1_x, 104);
    cyc(1);
    chk("enable_tick", p1_x, 102);
    idle();
    do_reset();
    p2_up = 1'b1;
    cyc(104);
    chk("mid_at60", p2_x, 60);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mid_reset", p2_x, 104);
    cyc(19);
    chk("mid_redebounce", p2_x, 104);
    cyc(1);
    chk("mid_resume", p2_x, 102);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
